// File: rtl/count_seq_ctrl.sv
// Command sequencer for the 16-bit up/down count block.
// Steps the counter pins until a CLEAR/UP_BY/DOWN_BY/GOTO command finishes.
module count_seq_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_arg,
  input  logic        abort,
  input  logic [15:0] cnt_value,
  output logic        cnt_en,
  output logic        cnt_up,
  output logic        cnt_reset,
  output logic        done,
  output logic        aborted,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_UP    = 2'd1;
  localparam logic [1:0] OP_DOWN  = 2'd2;
  localparam logic [1:0] OP_GOTO  = 2'd3;

  state_t      state;
  logic [15:0] remaining;
  logic        dir;
  logic        ab_q;

  logic [15:0] diff;
  logic        goto_up;
  logic [15:0] goto_n;

  // Shortest path to target; the exact half-way tie goes up.
  always_comb begin
    diff    = cmd_arg - cnt_value;
    goto_up = (diff <= 16'h8000);
    goto_n  = goto_up ? diff : (~diff + 16'd1);
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign cnt_reset = (state == S_CLEAR);
  assign cnt_en    = (state == S_RUN) & ~abort;
  assign cnt_up    = dir;
  assign done      = (state == S_DONE);
  assign aborted   = ab_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      remaining <= 16'd0;
      dir       <= 1'b0;
      ab_q      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_CLEAR: state <= S_CLEAR;
              OP_UP, OP_DOWN: begin
                remaining <= cmd_arg;
                dir       <= (cmd_op == OP_UP);
                state     <= (cmd_arg == 16'd0) ? S_DONE : S_RUN;
              end
              OP_GOTO: begin
                if (diff == 16'd0) begin
                  state <= S_DONE;
                end else begin
                  remaining <= goto_n;
                  dir       <= goto_up;
                  state     <= S_RUN;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_CLEAR: state <= S_DONE;
        S_RUN: begin
          if (abort) begin
            ab_q  <= 1'b1;
            state <= S_DONE;
          end else if (remaining == 16'd1) begin
            remaining <= 16'd0;
            state     <= S_DONE;
          end else begin
            remaining <= remaining - 16'd1;
          end
        end
        S_DONE: begin
          ab_q  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl driving a behavioural count model.
// Vector table for whole commands, hand sequences for abort and reset.
module tb_count_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_arg = 16'd0;
  logic        abort = 1'b0;
  logic [15:0] cnt_value = 16'd0;
  logic        cnt_en;
  logic        cnt_up;
  logic        cnt_reset;
  logic        done;
  logic        aborted;
  logic        busy;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural model of the controlled count block.
  always @(posedge clk) begin
    if (cnt_reset) cnt_value <= 16'd0;
    else if (cnt_en) cnt_value <= cnt_up ? cnt_value + 16'd1 : cnt_value - 16'd1;
  end

  count_seq_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .abort     (abort),
    .cnt_value (cnt_value),
    .cnt_en    (cnt_en),
    .cnt_up    (cnt_up),
    .cnt_reset (cnt_reset),
    .done      (done),
    .aborted   (aborted),
    .busy      (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, act, act, exp, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [15:0] arg,
                         input int abort_cyc, input logic exp_up,
                         output int lat, output int ens, output int rsts,
                         output int dirbad, output int ab);
    lat = 0; ens = 0; rsts = 0; dirbad = 0; ab = 0;
    @(negedge clk);
    chk("ready_before_accept", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int c = 1; c <= 40000; c++) begin
      abort = (c == abort_cyc);
      @(negedge clk);
      if (cnt_en) begin
        ens++;
        if (cnt_up !== exp_up) dirbad++;
      end
      if (cnt_reset) rsts++;
      if (done) begin
        lat = c;
        ab  = int'(aborted);
        break;
      end
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] arg;
    logic [15:0] exp_val;
    int          exp_en;
    int          exp_lat;
    logic        exp_up;
    int          exp_rst;
  } vec_t;

  vec_t v [12];

  initial begin
    int lat, ens, rsts, dirbad, ab;
    logic [15:0] held;

    v[0]  = '{2'd1, 16'd50,    16'd50,    50,    51,    1'b1, 0};
    v[1]  = '{2'd2, 16'd25,    16'd25,    25,    26,    1'b0, 0};
    v[2]  = '{2'd3, 16'hFFF0,  16'hFFF0,  41,    42,    1'b0, 0};
    v[3]  = '{2'd3, 16'h0019,  16'h0019,  41,    42,    1'b1, 0};
    v[4]  = '{2'd3, 16'h8019,  16'h8019,  32768, 32769, 1'b1, 0};
    v[5]  = '{2'd0, 16'h1234,  16'd0,     0,     2,     1'b1, 1};
    v[6]  = '{2'd1, 16'd123,   16'd123,   123,   124,   1'b1, 0};
    v[7]  = '{2'd0, 16'd0,     16'd0,     0,     2,     1'b1, 1};
    v[8]  = '{2'd1, 16'd0,     16'd0,     0,     1,     1'b1, 0};
    v[9]  = '{2'd3, 16'd0,     16'd0,     0,     1,     1'b1, 0};
    v[10] = '{2'd3, 16'hFFFF,  16'hFFFF,  1,     2,     1'b0, 0};
    v[11] = '{2'd0, 16'd0,     16'd0,     0,     2,     1'b0, 1};

    #2;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_en", int'(cnt_en), 0);
    chk("rst_up", int'(cnt_up), 0);
    chk("rst_creset", int'(cnt_reset), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_aborted", int'(aborted), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", int'(cmd_ready), 1);
    chk("post_rst_value", int'(cnt_value), 0);

    for (int i = 0; i < 12; i++) begin
      run_cmd(v[i].op, v[i].arg, 0, v[i].exp_up, lat, ens, rsts, dirbad, ab);
      chk($sformatf("v%0d_latency", i), lat, v[i].exp_lat);
      chk($sformatf("v%0d_en_cycles", i), ens, v[i].exp_en);
      chk($sformatf("v%0d_reset_cycles", i), rsts, v[i].exp_rst);
      chk($sformatf("v%0d_dir_errors", i), dirbad, 0);
      chk($sformatf("v%0d_aborted", i), ab, 0);
      chk($sformatf("v%0d_value", i), int'(cnt_value), int'(v[i].exp_val));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_clears", i), int'(done), 0);
      chk($sformatf("v%0d_ready_back", i), int'(cmd_ready), 1);
    end

    // UP_BY 100 with abort during the 10th RUN cycle: 9 steps taken.
    run_cmd(2'd1, 16'd100, 10, 1'b1, lat, ens, rsts, dirbad, ab);
    chk("abort_latency", lat, 11);
    chk("abort_en_cycles", ens, 9);
    chk("abort_flag", ab, 1);
    chk("abort_value", int'(cnt_value), 9);
    @(posedge clk);
    #1;
    chk("abort_done_clears", int'(done), 0);
    chk("abort_flag_clears", int'(aborted), 0);
    chk("abort_ready_back", int'(cmd_ready), 1);

    // Reset mid UP_BY: four steps land, then the enable drops at once.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'd1;
    cmd_arg   = 16'd100;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_run_en", int'(cnt_en), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_en", int'(cnt_en), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_ready", int'(cmd_ready), 1);
    held = cnt_value;
    chk("rst_mid_value", int'(held), 13);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_value", int'(cnt_value), 13);
    reset_n = 1'b1;
    begin
      int dcnt;
      dcnt = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (done) dcnt++;
      end
      chk("rst_no_done", dcnt, 0);
    end
    chk("rst_release_ready", int'(cmd_ready), 1);
    chk("rst_release_value", int'(cnt_value), 13);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/count_seq_ctrl.md
# count_seq_ctrl

Command-driven sequencer for the 16-bit up/down `count` block. It accepts step, clear and go-to commands over a valid/ready handshake and drives the counter's `en`/`up`/`reset` pins cycle by cycle until the command completes. It then pulses `done` and returns to idle. It sits between a host FSM or bus register and a `count` instance, so no other logic toggles the counter pins directly.

## Interface
- No parameters: widths are fixed at 16 bits to match `count`.
- `clk`  in  1  rising-edge clock, shared with `count`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_op`  in  2  opcode:
  - 0 = CLEAR
  - 1 = UP_BY
  - 2 = DOWN_BY
  - 3 = GOTO
- `cmd_arg`  in  16  step count for UP_BY/DOWN_BY, target value for GOTO, ignored for CLEAR.
- `abort`  in  1  terminate the running command.
- `cnt_value`  in  16  `count.out_data`.
- `cnt_en`  out  1  to `count.en`.
- `cnt_up`  out  1  to `count.up`.
- `cnt_reset`  out  1  to `count.reset`.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  qualifies `done`: the command ended by abort; valid only while `done`=1.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Controlled counter behaviour, applied at each posedge:
  - `reset`=1: value goes to 0.
  - else `en`=1: value goes to value±1 (+1 when `up`=1, -1 when `up`=0), mod 2^16.
  - else: value holds.
- States are IDLE, CLEAR, RUN and DONE.
  - `cmd_ready` = (state==IDLE).
  - `busy` = !IDLE.
  - `cnt_reset` = (state==CLEAR).
  - `cnt_en` = (state==RUN) & !abort.
  - `cnt_up` = latched direction bit; it holds its value outside RUN.
- Accept: a command is accepted when `cmd_valid` & `cmd_ready` are both high at a posedge. `cmd_op`, `cmd_arg` and `cnt_value` are sampled at that edge.
- CLEAR: IDLE→CLEAR. CLEAR lasts exactly 1 cycle, then →DONE.
- UP_BY n / DOWN_BY n:
  - `remaining`←n, and direction is set to 1 for UP_BY, 0 for DOWN_BY.
  - n==0: go directly to DONE, with no `cnt_en` pulse.
- GOTO t:
  - diff = (t − `cnt_value`) mod 2^16.
  - diff==0: →DONE.
  - 1 ≤ diff ≤ 0x8000: direction up, `remaining`=diff.
  - diff > 0x8000: direction down, `remaining`=2^16−diff.
  - This gives the shortest path, with the 0x8000 tie going up.
- RUN:
  - Each cycle with `cnt_en`=1 decrements `remaining`.
  - The cycle in which `remaining`==1 is the last step; at that edge the state goes to DONE.
  - Result: exactly `remaining` enable cycles, with no gaps.
- Abort:
  - `abort`=1 in RUN forces `cnt_en`=0 in that same cycle, and the state goes to DONE at the next edge with `aborted` set.
  - `abort` is ignored in IDLE, CLEAR and DONE.
- DONE: `done`=1 for 1 cycle, then →IDLE. `aborted` clears on leaving DONE.
- `remaining` is a 16-bit register, and 0x8000 is representable in it. No arithmetic overflow is possible.

## Timing
- Reset value of every output while `reset_n`=0, and immediately after release:
  - `cmd_ready`=1, `busy`=0.
  - `cnt_en`=0, `cnt_up`=0, `cnt_reset`=0.
  - `done`=0, `aborted`=0.
- The controller never clears the counter on its own reset.
- Reset asserted mid-RUN: `cnt_en` drops asynchronously, no `done` is generated, and the state returns to IDLE.
- With the accept at edge E0:
  - UP_BY/DOWN_BY/GOTO with n>0 steps: `cnt_en` is high in the n cycles between E0 and En, and the counter updates at E1..En.
  - `done` is high between En and En+1.
  - `cmd_ready` is high again after En+1.
  - Total: a command occupies n+2 cycles before the next accept.
- CLEAR: `cnt_reset` is high between E0 and E1, so `cnt_value`=0 after E1. `done` is high between E1 and E2.
- Zero-step commands: `done` is high between E0 and E1.
- `cmd_valid` held high continuously: commands are accepted back-to-back, at one every n+2 cycles.
- Abort seen in RUN before edge Ek: steps taken = k−1. `done` and `aborted` are high between Ek and Ek+1.

## Test plan
- Reset then UP_BY 50 from 0:
  - `cnt_value`=50.
  - Exactly 50 `cnt_en` cycles, then one `done` with `aborted`=0.
- From 50, DOWN_BY 25:
  - `cnt_value`=25.
  - `cnt_up`=0 throughout RUN.
  - `done` appears 26 cycles after the accept.
- GOTO:
  - GOTO 0xFFF0 from 25: the counter goes down through wrap in 41 steps and ends at 0xFFF0.
  - GOTO 0x8019 from 25: diff is exactly 0x8000, so it counts up 32768 steps.
- CLEAR at value 123:
  - `cnt_reset` high for exactly 1 cycle.
  - `cnt_value`=0.
  - `done` appears 2 cycles after the accept.
  - UP_BY 0 afterwards: `done` appears next cycle with no `cnt_en`.
- UP_BY 100 from 0 with `abort` pulsed in the 10th RUN cycle:
  - `cnt_value`=9.
  - `done` and `aborted` both 1 for one cycle.
  - `cmd_ready` returns 1 cycle later.
- `reset_n` pulled low mid-UP_BY: `cnt_en` goes to 0 immediately and `cnt_value` holds. After release, `cmd_ready`=1 and there is no `done`.
